// File: rtl/life_engine.sv
// life_engine: Conway B3/S23 grid with load/run/pause/step control, step-rate divider,
// saturating generation counter and stable/extinct detection.
module life_engine #(
  parameter int COLS    = 8,
  parameter int ROWS    = 8,
  parameter int DIVIDER = 23,
  parameter int GEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROWS*COLS-1:0] init_cells,
  input  logic                 load,
  input  logic                 run,
  input  logic                 step,
  input  logic                 wrap,
  input  logic                 halt_on_stable,
  output logic [ROWS*COLS-1:0] cells,
  output logic [GEN_W-1:0]     generation,
  output logic                 step_done,
  output logic                 stable,
  output logic                 extinct,
  output logic [1:0]           state
);
  localparam int N  = ROWS * COLS;
  localparam int DW = (DIVIDER > 0) ? DIVIDER : 1;
  typedef enum logic [1:0] {S_LOAD, S_PAUSED, S_RUNNING, S_HALTED} state_t;
  state_t           r_state, w_state_nx;
  logic [N-1:0]     r_cells, w_next;
  logic [GEN_W-1:0] r_gen;
  logic             r_stable, r_step_done;
  logic [DW-1:0]    r_div;
  logic             w_div_max, w_eval, w_same, w_div_clr, w_div_inc;
  // Edge validity masks turn off out-of-grid neighbours when the border is dead.
  for (genvar y = 0; y < ROWS; y++) begin : g_row
    for (genvar x = 0; x < COLS; x++) begin : g_col
      localparam int XL = (x + COLS - 1) % COLS;
      localparam int XR = (x + 1) % COLS;
      localparam int YU = (y + ROWS - 1) % ROWS;
      localparam int YD = (y + 1) % ROWS;
      logic       w_l, w_r, w_u, w_d;
      logic [7:0] w_nb;
      logic [3:0] w_cnt;
      assign w_l = wrap || (x != 0);
      assign w_r = wrap || (x != COLS - 1);
      assign w_u = wrap || (y != 0);
      assign w_d = wrap || (y != ROWS - 1);
      assign w_nb = {r_cells[YU*COLS+XL] & w_u & w_l, r_cells[YU*COLS+x] & w_u,
                     r_cells[YU*COLS+XR] & w_u & w_r, r_cells[y*COLS+XL] & w_l,
                     r_cells[y*COLS+XR] & w_r,        r_cells[YD*COLS+XL] & w_d & w_l,
                     r_cells[YD*COLS+x] & w_d,        r_cells[YD*COLS+XR] & w_d & w_r};
      assign w_cnt = 4'($countones(w_nb));
      assign w_next[y*COLS+x] = (w_cnt == 4'd3) || (r_cells[y*COLS+x] && w_cnt == 4'd2);
    end
  end
  assign w_same    = (w_next == r_cells);
  assign w_div_max = (DIVIDER == 0) || (r_div == '1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = r_state;
    if (r_state == S_LOAD)                         w_state_nx = S_PAUSED;
    else if (load)                                 w_state_nx = S_LOAD;
    else if (r_state == S_PAUSED && run)           w_state_nx = S_RUNNING;
    else if (r_state == S_RUNNING && !run)         w_state_nx = S_PAUSED;
    else if (w_eval && w_same && halt_on_stable)   w_state_nx = S_HALTED;
  end
  always_comb begin
    w_eval    = !load && ((r_state == S_PAUSED && !run && step) ||
                          (r_state == S_RUNNING && run && w_div_max));
    w_div_clr = (r_state == S_LOAD) || (r_state == S_PAUSED && run);
    w_div_inc = (r_state == S_RUNNING) && run;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cells     <= '0;
      r_gen       <= '0;
      r_stable    <= 1'b0;
      r_step_done <= 1'b0;
      r_div       <= '0;
    end else begin
      r_step_done <= w_eval;
      if (r_state == S_LOAD) begin
        r_cells  <= init_cells;
        r_gen    <= '0;
        r_stable <= 1'b0;
      end else if (w_eval) begin
        r_cells  <= w_next;
        r_gen    <= (r_gen == '1) ? r_gen : r_gen + 1'b1;
        r_stable <= w_same;
      end
      if (w_div_clr) r_div <= '0;
      else if (w_div_inc && DIVIDER != 0) r_div <= r_div + 1'b1;
    end
  end
  assign cells      = r_cells;
  assign generation = r_gen;
  assign step_done  = r_step_done;
  assign stable     = r_stable;
  assign extinct    = ~|r_cells;
  assign state      = r_state;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed and random stimulus against a cycle-level behavioural model.
module tb_life_engine;
  localparam int C = 5, R = 5, N = 25, GW = 3, DV = 2;
  localparam int GMAX = (1 << GW) - 1, DMAX = (1 << DV) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] init_cells = '0;
  logic load = 0, run = 0, step = 0, wrap = 0, halt_on_stable = 0;
  logic [N-1:0] cells;
  logic [GW-1:0] generation;
  logic step_done, stable, extinct;
  logic [1:0] state;
  always #5 clk = ~clk;
  life_engine #(.COLS(C), .ROWS(R), .DIVIDER(DV), .GEN_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .init_cells(init_cells), .load(load), .run(run), .step(step),
    .wrap(wrap), .halt_on_stable(halt_on_stable), .cells(cells), .generation(generation),
    .step_done(step_done), .stable(stable), .extinct(extinct), .state(state));
  int n_cmp = 0, n_err = 0;
  logic [N-1:0] m_cells;
  int m_gen, m_div, m_state;
  bit m_stable, m_sd;
  function automatic logic [N-1:0] life(logic [N-1:0] c, bit wr);
    logic [N-1:0] nx = '0;
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) begin
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) begin
              int xx = x + dx, yy = y + dy;
              if (wr) n += int'(c[((yy + R) % R) * C + (xx + C) % C]);
              else if (xx >= 0 && xx < C && yy >= 0 && yy < R) n += int'(c[yy * C + xx]);
            end
        nx[y * C + x] = (n == 3) || (c[y * C + x] && n == 2);
      end
    return nx;
  endfunction
  function automatic logic [N-1:0] pat(int a, int b = -1, int c = -1, int d = -1);
    logic [N-1:0] p = '0;
    if (a >= 0) p[a] = 1'b1;
    if (b >= 0) p[b] = 1'b1;
    if (c >= 0) p[c] = 1'b1;
    if (d >= 0) p[d] = 1'b1;
    return p;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    m_cells = '0; m_gen = 0; m_stable = 0; m_sd = 0; m_div = 0; m_state = 0;
  endtask
  task automatic model();
    bit ev = 0;
    logic [N-1:0] nx;
    if (!rst_n) begin
      mreset();
    end else if (m_state == 0) begin
      m_cells = init_cells; m_gen = 0; m_stable = 0; m_div = 0; m_sd = 0; m_state = 1;
    end else begin
      if (!load) begin
        if (m_state == 1) begin
          if (run) begin m_state = 2; m_div = 0; end
          else if (step) ev = 1;
        end else if (m_state == 2) begin
          if (!run) m_state = 1;
          else begin ev = (m_div == DMAX); m_div = (m_div + 1) % (DMAX + 1); end
        end
      end
      m_sd = ev;
      if (ev) begin
        nx = life(m_cells, wrap);
        m_stable = (nx == m_cells);
        m_cells = nx;
        m_gen = (m_gen < GMAX) ? m_gen + 1 : GMAX;
        if (m_stable && halt_on_stable) m_state = 3;
      end
      if (load) m_state = 0;
    end
  endtask
  task automatic check_all();
    check("cells", 32'(cells), 32'(m_cells));
    check("generation", 32'(generation), m_gen);
    check("stable", 32'(stable), 32'(m_stable));
    check("step_done", 32'(step_done), 32'(m_sd));
    check("extinct", 32'(extinct), 32'(m_cells == '0));
    check("state", 32'(state), m_state);
  endtask
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model();
      @(negedge clk);
      check_all();
    end
  endtask
  task automatic async_rst();
    #1 rst_n = 1'b0;
    #1 mreset();
    check("rst_state", 32'(state), 0);
    check("rst_cells", 32'(cells), 0);
  endtask
  task automatic do_load(logic [N-1:0] p);
    init_cells = p; load = 1; cyc(); load = 0; cyc();
  endtask
  task automatic do_step();
    step = 1; cyc(); step = 0;
  endtask
  initial begin
    mreset();
    @(negedge clk);
    check_all();
    check("reset_extinct", 32'(extinct), 1);
    init_cells = pat(11, 12, 13);
    rst_n = 1;
    cyc();
    check("tp1_paused", 32'(state), 1);
    do_step();
    check("tp1_cells1", 32'(cells), 32'(pat(7, 12, 17)));
    check("tp1_gen1", 32'(generation), 1);
    check("tp1_done", 32'(step_done), 1);
    cyc();
    check("tp1_done_low", 32'(step_done), 0);
    do_step();
    check("tp1_cells2", 32'(cells), 32'(pat(11, 12, 13)));
    check("tp1_gen2", 32'(generation), 2);
    check("tp1_stable", 32'(stable), 0);
    do_load(pat(5, 10, 15));
    do_step();
    check("dead_border", 32'(cells), 32'(pat(10, 11)));
    wrap = 1;
    do_load(pat(5, 10, 15));
    do_step();
    check("toroid", 32'(cells), 32'(pat(10, 11, 14)));
    wrap = 0; halt_on_stable = 1;
    do_load(pat(6, 7, 11, 12));
    run = 1;
    cyc(1 + DMAX + 1);
    check("halt_state", 32'(state), 3);
    check("halt_gen", 32'(generation), 1);
    check("halt_stable", 32'(stable), 1);
    repeat (20) begin step = 1'($urandom); cyc(); end
    step = 0;
    check("halt_frozen", 32'(generation), 1);
    load = 1; cyc(); load = 0;
    check("halt_load", 32'(state), 0);
    cyc();
    check("halt_paused", 32'(state), 1);
    check("halt_gen0", 32'(generation), 0);
    run = 0; halt_on_stable = 0;
    cyc();
    do_load(pat(11, 12, 13));
    run = 1;
    cyc(1 + 9 * (DMAX + 1));
    check("sat_gen", 32'(generation), GMAX);
    check("sat_running", 32'(state), 2);
    run = 0;
    cyc();
    check("sat_pause", 32'(state), 1);
    cyc(8);
    check("sat_cells", 32'(cells), 32'(pat(7, 12, 17)));
    do_load(pat(12));
    do_step();
    check("single_cells", 32'(cells), 0);
    check("single_extinct", 32'(extinct), 1);
    check("single_stable0", 32'(stable), 0);
    do_step();
    check("single_stable1", 32'(stable), 1);
    check("single_gen", 32'(generation), 2);
    do_load(pat(11, 12, 13));
    run = 1;
    cyc(3);
    async_rst();
    run = 0;
    cyc();
    rst_n = 1;
    cyc();
    check("rel_paused", 32'(state), 1);
    check("rel_cells", 32'(cells), 32'(pat(11, 12, 13)));
    check("rel_gen", 32'(generation), 0);
    load = 1; step = 1;
    cyc();
    load = 0; step = 0;
    check("load_vs_step", 32'(state), 0);
    check("load_vs_step_gen", 32'(generation), 0);
    check("load_vs_step_done", 32'(step_done), 0);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(39) == 0);
      if ($urandom_range(19) == 0) run = ~run;
      step = ($urandom_range(2) == 0);
      if ($urandom_range(29) == 0) wrap = ~wrap;
      if ($urandom_range(29) == 0) halt_on_stable = ~halt_on_stable;
      if (load) init_cells = N'($urandom & ($urandom_range(1) ? $urandom : 32'hffff_ffff));
      if ($urandom_range(499) == 0) begin
        async_rst();
        cyc();
        rst_n = 1;
      end
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
